imem_wr_arbiter: RTL

Shares the single byte-masked write port (port A) of the instruction memory between two requesters: the CPU store path (self-modifying code / MMIO imem writes) and the program loader (UART/DMA bootloader).
- Per-requester valid/ready handshake; round-robin arbitration.
- Burst lock for the loader, with beat-count and idle-timeout release.
- Registered outputs drive imem ena/wea/addra/dina directly.
- Read port B is untouched.

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 45 ++++
 rtl/imem_wr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory write-port arbiter.
// Holds memory geometry, requester ids and the lock FSM encoding.
package imem_arb_pkg;

  localparam int IMEM_AW = 14;
  localparam int IMEM_DW = 32;
  localparam int IMEM_MW = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant between CPU and loader.
// The lock input hands the grant to the loader unconditionally.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_cpu,
  input  logic req_ldr,
  input  logic lock,
  output logic gnt_cpu,
  output logic gnt_ldr
);

  req_id_e last_q, last_d;
  logic    pick_ldr;

  always_comb begin
    pick_ldr = 1'b0;
    if (lock)
      pick_ldr = 1'b1;
    else if (req_cpu && req_ldr)
      pick_ldr = (last_q == REQ_CPU);
    else
      pick_ldr = req_ldr;

    gnt_ldr = req_ldr & pick_ldr;
    gnt_cpu = req_cpu & ~pick_ldr;

    last_d = last_q;
    if (gnt_ldr)
      last_d = REQ_LDR;
    else if (gnt_cpu)
      last_d = REQ_CPU;
  end

  // Starting at LDR lets the CPU win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= REQ_LDR;
    else
      last_q <= last_d;
  end

endmodule

// File: rtl/imem_wr_arbiter.sv
// Arbitrates imem port A writes between CPU stores and the loader.
// Define IMEM_ARB_STATS_EN to add write/stall statistic counters.
module imem_wr_arbiter
  import imem_arb_pkg::*;
#(
  parameter int AW            = IMEM_AW,
  parameter int DW            = IMEM_DW,
  parameter int MW            = IMEM_MW,
  parameter int MAX_BURST     = 64,
  parameter int LOCK_IDLE_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [MW-1:0] cpu_wmask,
  input  logic          ldr_valid,
  output logic          ldr_ready,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic [MW-1:0] ldr_wmask,
  input  logic          ldr_last,
  output logic          imem_ena,
  output logic [MW-1:0] imem_wea,
  output logic [AW-1:0] imem_addra,
  output logic [DW-1:0] imem_dina,
  output logic          locked
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]   cpu_wr_count,
  output logic [31:0]   ldr_wr_count,
  output logic [31:0]   cpu_stall_count
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(LOCK_IDLE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ena_q, ena_d;
  logic [MW-1:0] wea_q, wea_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;

  logic          cpu_acc, ldr_acc, acc;
  logic [MW-1:0] sel_mask;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (cpu_valid),
    .req_ldr (ldr_valid),
    .lock    (state_q == LOCK),
    .gnt_cpu (cpu_acc),
    .gnt_ldr (ldr_acc)
  );

  assign cpu_ready = cpu_acc;
  assign ldr_ready = ldr_acc;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    unique case (state_q)
      ARB: begin
        if (ldr_acc && !ldr_last && MAX_BURST > 1) begin
          state_d = LOCK;
          beat_d  = BW'(1);
          idle_d  = '0;
        end
      end
      LOCK: begin
        // In LOCK the loader is accepted whenever it is valid.
        if (ldr_acc) begin
          beat_d = beat_q + BW'(1);
          idle_d = '0;
          if (ldr_last || beat_d == BW'(MAX_BURST))
            state_d = ARB;
        end else begin
          idle_d = idle_q + IW'(1);
          if (idle_d == IW'(LOCK_IDLE_MAX))
            state_d = ARB;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    acc      = cpu_acc | ldr_acc;
    sel_mask = ldr_acc ? ldr_wmask : cpu_wmask;
    ena_d    = acc & (|sel_mask);
    wea_d    = acc ? sel_mask : '0;
    addr_d   = addr_q;
    din_d    = din_q;
    if (acc) begin
      addr_d = ldr_acc ? ldr_addr : cpu_addr;
      din_d  = ldr_acc ? ldr_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      beat_q  <= '0;
      idle_q  <= '0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign imem_ena   = ena_q;
  assign imem_wea   = wea_q;
  assign imem_addra = addr_q;
  assign imem_dina  = din_q;
  assign locked     = (state_q == LOCK);

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] cpu_wr_q, cpu_wr_d;
  logic [31:0] ldr_wr_q, ldr_wr_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    cpu_wr_d = cpu_wr_q + {31'd0, cpu_acc & (|cpu_wmask)};
    ldr_wr_d = ldr_wr_q + {31'd0, ldr_acc & (|ldr_wmask)};
    stall_d  = stall_q + {31'd0, cpu_valid & ~cpu_acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_wr_q <= '0;
      ldr_wr_q <= '0;
      stall_q  <= '0;
    end else begin
      cpu_wr_q <= cpu_wr_d;
      ldr_wr_q <= ldr_wr_d;
      stall_q  <= stall_d;
    end
  end

  assign cpu_wr_count    = cpu_wr_q;
  assign ldr_wr_count    = ldr_wr_q;
  assign cpu_stall_count = stall_q;
`endif

endmodule
